// File: rtl/pow_seq_pkg.sv
// Shared definitions for the sequential power unit: FSM state encoding and
// base-selection mode constants.
package pow_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_BASE = 1'b0;
    localparam logic MODE_POW2 = 1'b1;

endpackage

// File: rtl/mul_ovf.sv
// Unsigned WIDTH x WIDTH multiplier returning the low half of the product and
// a flag that is set when the upper half is nonzero.
module mul_ovf #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic             ovf
);

    logic [2*WIDTH-1:0] prod_s;

    // Full-width product, zero-extended operands so no bits are lost
    always_comb begin
        prod_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        lo     = prod_s[WIDTH-1:0];
        ovf    = |prod_s[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/pow_seq.sv
// Sequential base^exp mod 2^WIDTH by left-to-right square-and-multiply, one
// exponent bit per clock, with exact overflow and a start/done handshake.
module pow_seq
    import pow_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int EXP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    state_e           state_r;
    logic [WIDTH-1:0] base_r;
    logic [EXP_W-1:0] exp_r;
    logic [WIDTH-1:0] acc_r;
    logic             ovf_r;
    logic [IDX_W-1:0] idx_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             overflow_r;

    logic [WIDTH-1:0] sq_lo_s;
    logic             sq_ovf_s;
    logic [WIDTH-1:0] mul_lo_s;
    logic             mul_ovf_s;
    logic             bit_s;
    logic [WIDTH-1:0] acc_nxt_s;
    logic             ovf_nxt_s;
    logic [WIDTH-1:0] base_sel_s;

    mul_ovf #(.WIDTH(WIDTH)) u_sq (
        .a   (acc_r),
        .b   (acc_r),
        .lo  (sq_lo_s),
        .ovf (sq_ovf_s)
    );

    mul_ovf #(.WIDTH(WIDTH)) u_mul (
        .a   (sq_lo_s),
        .b   (base_r),
        .lo  (mul_lo_s),
        .ovf (mul_ovf_s)
    );

    // Operand selection at launch: pow2 mode replaces the base with 2
    always_comb begin
        base_sel_s = base;
        if (mode == MODE_POW2) begin
            base_sel_s = WIDTH'(2'd2);
        end else begin
            base_sel_s = base;
        end
    end

    // One square-and-multiply step; the multiply only counts when the bit is set
    always_comb begin
        bit_s     = exp_r[idx_r];
        acc_nxt_s = sq_lo_s;
        ovf_nxt_s = ovf_r | sq_ovf_s;
        if (bit_s) begin
            acc_nxt_s = mul_lo_s;
            ovf_nxt_s = ovf_r | sq_ovf_s | mul_ovf_s;
        end else begin
            acc_nxt_s = sq_lo_s;
            ovf_nxt_s = ovf_r | sq_ovf_s;
        end
    end

    // Control FSM with operand, accumulator and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            base_r     <= {WIDTH{1'b0}};
            exp_r      <= {EXP_W{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            ovf_r      <= 1'b0;
            idx_r      <= {IDX_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        base_r  <= base_sel_s;
                        exp_r   <= exp;
                        acc_r   <= WIDTH'(1'b1);
                        ovf_r   <= 1'b0;
                        idx_r   <= IDX_W'(EXP_W - 1);
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_nxt_s;
                    ovf_r <= ovf_nxt_s;
                    if (idx_r == {IDX_W{1'b0}}) begin
                        result_r   <= acc_nxt_s;
                        overflow_r <= ovf_nxt_s;
                        done_r     <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r - IDX_W'(1'b1);
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_pow_seq.sv
// Directed bench for pow_seq (WIDTH=8, EXP_W=4): hand-computed results,
// latency, handshake and reset/abort behaviour.
module tb_pow_seq;

    localparam int WIDTH = 8;
    localparam int EXP_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] base;
    logic [EXP_W-1:0] exp;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    int n_cmp;
    int n_err;

    pow_seq #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .base     (base),
        .exp      (exp),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Launch one operation and check latency, single done pulse and outputs
    task automatic do_op(input string tag, input logic m, input logic [7:0] b,
                         input logic [3:0] e, input logic [7:0] r, input logic o);
        int  n;
        bit  seen;
        @(negedge clk);
        start = 1'b1; mode = m; base = b; exp = e;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; base = 8'hA5; exp = 4'hF;
        chk({tag, " busy"}, busy, 1);
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
        end
        chk({tag, " latency"}, n, EXP_W);
        chk({tag, " result"}, result, r);
        chk({tag, " overflow"}, overflow, o);
        @(posedge clk); #1;
        chk({tag, " done pulse"}, done, 0);
        @(posedge clk); #1;
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " result held"}, result, r);
    endtask

    initial begin
        int dones;
        logic [7:0] first_res;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b1; mode = 1'b0; base = 8'd7; exp = 4'd3;

        // Reset held with start asserted
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst busy", busy, 0);
            chk("rst done", done, 0);
            chk("rst result", result, 0);
            chk("rst overflow", overflow, 0);
        end
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        do_op("3^4",      1'b0, 8'd3,   4'd4,  8'd81,  1'b0);
        do_op("3^5",      1'b0, 8'd3,   4'd5,  8'd243, 1'b0);
        do_op("3^6",      1'b0, 8'd3,   4'd6,  8'd217, 1'b1);
        do_op("2^7",      1'b0, 8'd2,   4'd7,  8'd128, 1'b0);
        do_op("pow2 7",   1'b1, 8'hFF,  4'd7,  8'd128, 1'b0);
        do_op("pow2 8",   1'b1, 8'hFF,  4'd8,  8'd0,   1'b1);
        do_op("pow2 0",   1'b1, 8'h37,  4'd0,  8'd1,   1'b0);
        do_op("0^0",      1'b0, 8'd0,   4'd0,  8'd1,   1'b0);
        do_op("0^9",      1'b0, 8'd0,   4'd9,  8'd0,   1'b0);
        do_op("1^15",     1'b0, 8'd1,   4'd15, 8'd1,   1'b0);
        do_op("255^1",    1'b0, 8'd255, 4'd1,  8'd255, 1'b0);
        do_op("255^2",    1'b0, 8'd255, 4'd2,  8'd1,   1'b1);

        // Start pulsed mid-RUN with new operands must be ignored
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base = 8'd3; exp = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; first_res = 8'd0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                start = 1'b1; base = 8'd2; exp = 4'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                if (dones == 0) first_res = result;
                dones++;
            end
        end
        start = 1'b0;
        chk("ignore done count", dones, 1);
        chk("ignore result", first_res, 243);

        // Reset mid-RUN aborts without a done
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base = 8'd3; exp = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort busy", busy, 0);
        chk("abort result", result, 0);
        chk("abort overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort no done", dones, 0);
        do_op("after abort", 1'b0, 8'd3, 4'd4, 8'd81, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
